// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FP issue sequencer:
//   - decoder op codes (FPU_FADD_D .. FPU_FMV_D_X)
//   - op-class enum and classification helpers
//   - canonical NaN constants (double, and NaN-boxed single)
//   - sequencer FSM state encoding
// Op codes with bit 0 set below 6'b100000 are single precision.
// -----------------------------------------------------------------------------
package fpu_pkg;

  localparam int FPU_OP_W = 6;

  // Multi-cycle arithmetic: 000000 - 001001
  localparam logic [FPU_OP_W-1:0] FPU_FADD_D   = 6'b000000;
  localparam logic [FPU_OP_W-1:0] FPU_FADD_S   = 6'b000001;
  localparam logic [FPU_OP_W-1:0] FPU_FSUB_D   = 6'b000010;
  localparam logic [FPU_OP_W-1:0] FPU_FSUB_S   = 6'b000011;
  localparam logic [FPU_OP_W-1:0] FPU_FMUL_D   = 6'b000100;
  localparam logic [FPU_OP_W-1:0] FPU_FMUL_S   = 6'b000101;
  localparam logic [FPU_OP_W-1:0] FPU_FDIV_D   = 6'b000110;
  localparam logic [FPU_OP_W-1:0] FPU_FDIV_S   = 6'b000111;
  localparam logic [FPU_OP_W-1:0] FPU_FSQRT_D  = 6'b001000;
  localparam logic [FPU_OP_W-1:0] FPU_FSQRT_S  = 6'b001001;

  // Single-cycle fast unit: 010000 - 011111, 100000, 100001
  localparam logic [FPU_OP_W-1:0] FPU_FMIN_D   = 6'b010000;
  localparam logic [FPU_OP_W-1:0] FPU_FMIN_S   = 6'b010001;
  localparam logic [FPU_OP_W-1:0] FPU_FMAX_D   = 6'b010010;
  localparam logic [FPU_OP_W-1:0] FPU_FMAX_S   = 6'b010011;
  localparam logic [FPU_OP_W-1:0] FPU_FEQ_D    = 6'b010100;
  localparam logic [FPU_OP_W-1:0] FPU_FEQ_S    = 6'b010101;
  localparam logic [FPU_OP_W-1:0] FPU_FLT_D    = 6'b010110;
  localparam logic [FPU_OP_W-1:0] FPU_FLT_S    = 6'b010111;
  localparam logic [FPU_OP_W-1:0] FPU_FLE_D    = 6'b011000;
  localparam logic [FPU_OP_W-1:0] FPU_FLE_S    = 6'b011001;
  localparam logic [FPU_OP_W-1:0] FPU_FSGNJ_D  = 6'b011010;
  localparam logic [FPU_OP_W-1:0] FPU_FSGNJ_S  = 6'b011011;
  localparam logic [FPU_OP_W-1:0] FPU_FSGNJN_D = 6'b011100;
  localparam logic [FPU_OP_W-1:0] FPU_FSGNJN_S = 6'b011101;
  localparam logic [FPU_OP_W-1:0] FPU_FSGNJX_D = 6'b011110;
  localparam logic [FPU_OP_W-1:0] FPU_FSGNJX_S = 6'b011111;
  localparam logic [FPU_OP_W-1:0] FPU_FMV_X_D  = 6'b100000;
  localparam logic [FPU_OP_W-1:0] FPU_FMV_D_X  = 6'b100001;

  localparam logic [63:0] CANON_NAN_D = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] CANON_NAN_S = 64'hFFFF_FFFF_7FC0_0000;

  typedef enum logic [1:0] {
    OPC_ARITH,
    OPC_FAST,
    OPC_ILLEGAL
  } op_class_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARITH,
    ST_WB
  } state_e;

  function automatic op_class_e op_class(input logic [FPU_OP_W-1:0] op);
    if (op <= FPU_FSQRT_S) begin
      return OPC_ARITH;
    end
    if ((op >= FPU_FMIN_D && op <= FPU_FSGNJX_S) || op == FPU_FMV_X_D || op == FPU_FMV_D_X) begin
      return OPC_FAST;
    end
    return OPC_ILLEGAL;
  endfunction

  // The moves (1000xx) are excluded: their result is always a raw 64-bit copy.
  function automatic logic is_single(input logic [FPU_OP_W-1:0] op);
    return (op < FPU_FMV_X_D) && op[0];
  endfunction

  function automatic logic is_compare(input logic [FPU_OP_W-1:0] op);
    return (op >= FPU_FEQ_D) && (op <= FPU_FLE_S);
  endfunction

endpackage

// File: rtl/fpu_result_fmt.sv
// -----------------------------------------------------------------------------
// fpu_result_fmt
// Combinational result formatter for writeback.
//   op      : op code the result belongs to
//   fpu_rd  : 1 = destination is the FP register file
//   raw     : unformatted result from the fast or arithmetic unit
//   fmt     : formatted result
// Single-precision results written to FP registers are NaN-boxed; compares
// written to integer registers keep only their boolean bit; everything else
// passes through unchanged.
// -----------------------------------------------------------------------------
module fpu_result_fmt
  import fpu_pkg::*;
#(
  parameter int BUS_WIDTH  = 64,
  parameter int FPU_OP_LEN = 6
) (
  input  logic [FPU_OP_LEN-1:0] op,
  input  logic                  fpu_rd,
  input  logic [BUS_WIDTH-1:0]  raw,
  output logic [BUS_WIDTH-1:0]  fmt
);

  // NOTE: every signal written in always_comb is given a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    fmt = raw;
    if (fpu_rd && is_single(op)) begin
      fmt = {{(BUS_WIDTH-32){1'b1}}, raw[31:0]};
    end else if (!fpu_rd && is_compare(op)) begin
      fmt = {{(BUS_WIDTH-1){1'b0}}, raw[0]};
    end
  end

endmodule

// File: rtl/fpu_issue_seq.sv
// -----------------------------------------------------------------------------
// fpu_issue_seq
// FP issue sequencer between the FP decoder and writeback. Accepts one op at a
// time, routes it to the combinational fast unit or to the multi-cycle
// arithmetic unit, formats the result and holds it for writeback.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      op handshake from the decoder
//   in_op, in_fpu_rd         op code, 1 = FP destination
//   in_rd_addr               destination register index
//   in_rs1_data/in_rs2_data  operands
//   fast_op/a/b              combinational feed to the fast unit
//   fast_result              fast unit result (same cycle)
//   arith_start              one-cycle start pulse to the arithmetic unit
//   arith_op/a/b             registered op and operands for the arithmetic unit
//   arith_done/arith_result  arithmetic completion pulse and result
//   wb_valid / wb_ready      result handshake to writeback
//   wb_fp, wb_rd_addr        destination file and index
//   wb_data                  formatted result
//   wb_illegal               op code was unassigned (qualified by wb_valid)
//   timeout_err              sticky arithmetic-timeout flag
// -----------------------------------------------------------------------------
module fpu_issue_seq
  import fpu_pkg::*;
#(
  parameter int BUS_WIDTH      = 64,
  parameter int FPU_OP_LEN     = 6,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FPU_OP_LEN-1:0] in_op,
  input  logic                  in_fpu_rd,
  input  logic [4:0]            in_rd_addr,
  input  logic [BUS_WIDTH-1:0]  in_rs1_data,
  input  logic [BUS_WIDTH-1:0]  in_rs2_data,
  output logic [FPU_OP_LEN-1:0] fast_op,
  output logic [BUS_WIDTH-1:0]  fast_a,
  output logic [BUS_WIDTH-1:0]  fast_b,
  input  logic [BUS_WIDTH-1:0]  fast_result,
  output logic                  arith_start,
  output logic [FPU_OP_LEN-1:0] arith_op,
  output logic [BUS_WIDTH-1:0]  arith_a,
  output logic [BUS_WIDTH-1:0]  arith_b,
  input  logic                  arith_done,
  input  logic [BUS_WIDTH-1:0]  arith_result,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic                  wb_fp,
  output logic [4:0]            wb_rd_addr,
  output logic [BUS_WIDTH-1:0]  wb_data,
  output logic                  wb_illegal,
  output logic                  timeout_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e                  state_q, state_d;
  logic [FPU_OP_LEN-1:0]   op_q;
  logic [BUS_WIDTH-1:0]    a_q, b_q;
  logic [4:0]              rd_q;
  logic                    fpu_rd_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [BUS_WIDTH-1:0]    wb_data_q;
  logic                    wb_illegal_q;
  logic                    timeout_q;

  op_class_e               in_class;
  logic                    timeout_hit;
  logic [FPU_OP_LEN-1:0]   fmt_op;
  logic                    fmt_fpu_rd;
  logic [BUS_WIDTH-1:0]    fmt_raw;
  logic [BUS_WIDTH-1:0]    fmt_data;
  logic [BUS_WIDTH-1:0]    nan_data;

  // Fast unit is driven straight from the decoder so its result is ready in
  // the accept cycle.
  assign fast_op = in_op;
  assign fast_a  = in_rs1_data;
  assign fast_b  = in_rs2_data;

  assign in_class    = op_class(in_op);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign nan_data    = op_q[0] ? BUS_WIDTH'(CANON_NAN_S) : BUS_WIDTH'(CANON_NAN_D);

  // One formatter serves both paths: in IDLE it formats the fast result of the
  // op being accepted, otherwise the arithmetic result of the captured op.
  always_comb begin
    fmt_op     = op_q;
    fmt_fpu_rd = fpu_rd_q;
    fmt_raw    = arith_result;
    if (state_q == ST_IDLE) begin
      fmt_op     = in_op;
      fmt_fpu_rd = in_fpu_rd;
      fmt_raw    = fast_result;
    end
  end

  fpu_result_fmt #(
    .BUS_WIDTH  (BUS_WIDTH),
    .FPU_OP_LEN (FPU_OP_LEN)
  ) u_fmt (
    .op     (fmt_op),
    .fpu_rd (fmt_fpu_rd),
    .raw    (fmt_raw),
    .fmt    (fmt_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = (in_class == OPC_ARITH) ? ST_ARITH : ST_WB;
        end
      end
      ST_ARITH: begin
        if (arith_done || timeout_hit) begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        if (wb_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rd_q         <= '0;
      fpu_rd_q     <= 1'b0;
      cnt_q        <= '0;
      wb_data_q    <= '0;
      wb_illegal_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_q         <= in_op;
            a_q          <= in_rs1_data;
            b_q          <= in_rs2_data;
            rd_q         <= in_rd_addr;
            fpu_rd_q     <= in_fpu_rd;
            cnt_q        <= '0;
            wb_illegal_q <= (in_class == OPC_ILLEGAL);
            if (in_class == OPC_FAST) begin
              wb_data_q <= fmt_data;
            end else if (in_class == OPC_ILLEGAL) begin
              wb_data_q <= '0;
            end
          end
        end
        ST_ARITH: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // A done arriving in the last allowed cycle still delivers its result.
          if (arith_done) begin
            wb_data_q <= fmt_data;
          end else if (timeout_hit) begin
            wb_data_q <= nan_data;
            timeout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign wb_valid    = (state_q == ST_WB);
  assign arith_start = (state_q == ST_ARITH) && (cnt_q == '0);
  assign arith_op    = op_q;
  assign arith_a     = a_q;
  assign arith_b     = b_q;
  assign wb_fp       = fpu_rd_q;
  assign wb_rd_addr  = rd_q;
  assign wb_data     = wb_data_q;
  assign wb_illegal  = wb_illegal_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_fpu_issue_seq.sv
// -----------------------------------------------------------------------------
// tb_fpu_issue_seq
// Self-checking bench for fpu_issue_seq. The bench plays decoder, fast unit,
// arithmetic unit and writeback; expected results come from a small model of
// the op-class and formatting rules.
// -----------------------------------------------------------------------------
module tb_fpu_issue_seq;
  import fpu_pkg::*;

  localparam int BW  = 64;
  localparam int OPL = 6;
  localparam int TMO = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [OPL-1:0]  in_op = '0;
  logic            in_fpu_rd = 1'b0;
  logic [4:0]      in_rd_addr = '0;
  logic [BW-1:0]   in_rs1_data = '0;
  logic [BW-1:0]   in_rs2_data = '0;
  logic [OPL-1:0]  fast_op;
  logic [BW-1:0]   fast_a, fast_b;
  logic [BW-1:0]   fast_result = '0;
  logic            arith_start;
  logic [OPL-1:0]  arith_op;
  logic [BW-1:0]   arith_a, arith_b;
  logic            arith_done = 1'b0;
  logic [BW-1:0]   arith_result = '0;
  logic            wb_valid;
  logic            wb_ready = 1'b0;
  logic            wb_fp;
  logic [4:0]      wb_rd_addr;
  logic [BW-1:0]   wb_data;
  logic            wb_illegal;
  logic            timeout_err;

  int   n_vec = 0;
  int   n_err = 0;
  logic exp_timeout = 1'b0;

  fpu_issue_seq #(
    .BUS_WIDTH      (BW),
    .FPU_OP_LEN     (OPL),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_fpu_rd    (in_fpu_rd),
    .in_rd_addr   (in_rd_addr),
    .in_rs1_data  (in_rs1_data),
    .in_rs2_data  (in_rs2_data),
    .fast_op      (fast_op),
    .fast_a       (fast_a),
    .fast_b       (fast_b),
    .fast_result  (fast_result),
    .arith_start  (arith_start),
    .arith_op     (arith_op),
    .arith_a      (arith_a),
    .arith_b      (arith_b),
    .arith_done   (arith_done),
    .arith_result (arith_result),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_fp        (wb_fp),
    .wb_rd_addr   (wb_rd_addr),
    .wb_data      (wb_data),
    .wb_illegal   (wb_illegal),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- reference model ----------------
  // 0 = arith, 1 = fast, 2 = illegal
  function automatic int model_class(input logic [5:0] op);
    int v;
    v = int'(op);
    if (v <= 9) return 0;
    if ((v >= 16 && v <= 31) || v == 32 || v == 33) return 1;
    return 2;
  endfunction

  function automatic logic [63:0] model_fmt(input logic [5:0] op, input logic fprd,
                                            input logic [63:0] r);
    int v;
    v = int'(op);
    if (fprd && v < 32 && (v % 2 == 1)) return {32'hFFFF_FFFF, r[31:0]};
    if (!fprd && v >= 20 && v <= 25) return {63'd0, r[0]};
    return r;
  endfunction

  function automatic logic [5:0] rand_op(input int cls);
    int x;
    if (cls == 0) return 6'($urandom_range(0, 9));
    if (cls == 1) begin
      x = int'($urandom_range(0, 17));
      return (x < 16) ? 6'(16 + x) : 6'(32 + x - 16);
    end
    x = int'($urandom_range(0, 35));
    return (x < 6) ? 6'(10 + x) : 6'(34 + x - 6);
  endfunction

  // Issues one op and follows it to writeback. done_dly is the ARITH cycle
  // (0 = start cycle) in which arith_done is pulsed; >= TMO means never.
  task automatic run_op(input logic [5:0] op, input logic fprd, input logic [63:0] raw,
                        input int done_dly, input int stall);
    logic [4:0]  rd;
    logic [63:0] a, b, exp_data;
    logic        exp_ill;
    int          budget, n_arith, cls;
    rd  = 5'($urandom);
    a   = {$urandom, $urandom};
    b   = {$urandom, $urandom};
    cls = model_class(op);
    budget = 0;
    while (in_ready !== 1'b1 && budget < 200) begin
      tick();
      budget++;
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_wait op=%b in_ready=%b expected 1", op, in_ready);
    end
    in_valid = 1'b1; in_op = op; in_fpu_rd = fprd; in_rd_addr = rd;
    in_rs1_data = a; in_rs2_data = b;
    fast_result = (cls == 1) ? raw : {$urandom, $urandom};
    #1;
    n_vec++;
    if (fast_op !== op || fast_a !== a || fast_b !== b) begin
      n_err++;
      $display("FAIL fast_feed got op=%b a=%h b=%h expected op=%b a=%h b=%h",
               fast_op, fast_a, fast_b, op, a, b);
    end
    tick();
    // Upstream is free to change after the accept edge.
    in_valid = 1'b0; in_op = 6'($urandom); in_fpu_rd = ~fprd;
    in_rs1_data = {$urandom, $urandom}; in_rs2_data = {$urandom, $urandom};
    fast_result = {$urandom, $urandom};
    exp_ill = 1'b0;
    if (cls == 0) begin
      n_arith = (done_dly < TMO) ? done_dly + 1 : TMO;
      n_vec++;
      if (arith_op !== op || arith_a !== a || arith_b !== b) begin
        n_err++;
        $display("FAIL arith_operands got op=%b a=%h b=%h expected op=%b a=%h b=%h",
                 arith_op, arith_a, arith_b, op, a, b);
      end
      for (int c = 0; c < n_arith; c++) begin
        n_vec++;
        if (wb_valid !== 1'b0 || in_ready !== 1'b0 || arith_start !== (c == 0) ||
            timeout_err !== exp_timeout) begin
          n_err++;
          $display("FAIL arith_wait cyc=%0d got wb_valid=%b in_ready=%b start=%b tmo=%b expected 0 0 %b %b",
                   c, wb_valid, in_ready, arith_start, timeout_err, (c == 0), exp_timeout);
        end
        arith_done   = (c == done_dly);
        arith_result = raw;
        tick();
      end
      arith_done = 1'b0;
      arith_result = {$urandom, $urandom};
      if (done_dly < TMO) begin
        exp_data = model_fmt(op, fprd, raw);
      end else begin
        exp_data = op[0] ? 64'hFFFF_FFFF_7FC0_0000 : 64'h7FF8_0000_0000_0000;
        exp_timeout = 1'b1;
      end
    end else begin
      n_vec++;
      if (arith_start !== 1'b0) begin
        n_err++;
        $display("FAIL no_start op=%b arith_start=%b expected 0", op, arith_start);
      end
      exp_data = (cls == 1) ? model_fmt(op, fprd, raw) : 64'd0;
      exp_ill  = (cls == 2);
    end
    for (int s = 0; s <= stall; s++) begin
      n_vec++;
      if (wb_valid !== 1'b1 || in_ready !== 1'b0 || wb_data !== exp_data || wb_fp !== fprd ||
          wb_rd_addr !== rd || wb_illegal !== exp_ill || timeout_err !== exp_timeout ||
          arith_start !== 1'b0) begin
        n_err++;
        $display("FAIL wb op=%b s=%0d got v=%b rdy=%b d=%h fp=%b rd=%0d ill=%b tmo=%b st=%b expected 1 0 %h %b %0d %b %b 0",
                 op, s, wb_valid, in_ready, wb_data, wb_fp, wb_rd_addr, wb_illegal,
                 timeout_err, arith_start, exp_data, fprd, rd, exp_ill, exp_timeout);
      end
      // Stray completions outside ARITH must be ignored.
      arith_done = 1'(($urandom_range(0, 1)));
      arith_result = {$urandom, $urandom};
      if (s == stall) begin
        wb_ready = 1'b1;
        in_valid = 1'b1;
        in_op = rand_op(1);
      end
      tick();
    end
    wb_ready = 1'b0;
    arith_done = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL wb_release op=%b got in_ready=%b wb_valid=%b expected 1 0",
               op, in_ready, wb_valid);
    end
    in_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #3;
    n_vec++;
    if (in_ready !== 1'b1 || wb_valid !== 1'b0 || arith_start !== 1'b0 || arith_op !== '0 ||
        arith_a !== '0 || arith_b !== '0 || wb_fp !== 1'b0 || wb_rd_addr !== '0 ||
        wb_data !== '0 || wb_illegal !== 1'b0 || timeout_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset got rdy=%b v=%b st=%b op=%b d=%h ill=%b tmo=%b expected 1 0 0 0 0 0 0",
               in_ready, wb_valid, arith_start, arith_op, wb_data, wb_illegal, timeout_err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fast();
    run_op(FPU_FSGNJ_S, 1'b1, 64'h0000_0000_3F80_0000, 0, 0);
    run_op(FPU_FLT_D,   1'b0, 64'hDEAD_BEEF_0000_0001, 0, 1);
    run_op(FPU_FMV_X_D, 1'b0, 64'h0123_4567_89AB_CDEF, 0, 0);
  endtask

  task automatic test_arith();
    run_op(FPU_FDIV_D, 1'b1, 64'h4000_0000_0000_0000, 20, 3);
    run_op(FPU_FADD_S, 1'b1, 64'h1234_5678_4049_0FDB, 0, 0);
    run_op(FPU_FMUL_D, 1'b1, 64'hC000_0000_0000_0001, TMO - 1, 0);
  endtask

  task automatic test_timeout();
    run_op(FPU_FSQRT_S, 1'b1, 64'h0, TMO + 10, 1);
    run_op(FPU_FEQ_S, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0);
    run_op(FPU_FSUB_D, 1'b1, 64'h0, TMO, 0);
  endtask

  task automatic test_illegal();
    run_op(6'b111000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 2);
    run_op(6'b001010, 1'b0, 64'h5555_5555_5555_5555, 0, 0);
  endtask

  task automatic test_back_to_back();
    int cls, dly, pick;
    for (int i = 0; i < 40; i++) begin
      cls  = int'($urandom_range(0, 2));
      pick = int'($urandom_range(0, 15));
      dly  = (pick == 0) ? TMO - 1 : (pick == 1) ? TMO + 5 : int'($urandom_range(0, 12));
      run_op(rand_op(cls), 1'($urandom_range(0, 1)), {$urandom, $urandom}, dly,
             int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid_arith();
    in_valid = 1'b1; in_op = FPU_FDIV_D; in_fpu_rd = 1'b1; in_rd_addr = 5'd7;
    in_rs1_data = 64'h1; in_rs2_data = 64'h2;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    exp_timeout = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || wb_valid !== 1'b0 || arith_start !== 1'b0 ||
        timeout_err !== 1'b0 || arith_op !== '0) begin
      n_err++;
      $display("FAIL mid_reset got rdy=%b v=%b st=%b tmo=%b op=%b expected 1 0 0 0 0",
               in_ready, wb_valid, arith_start, timeout_err, arith_op);
    end
    #1;
    rst = 1'b0;
    tick();
    arith_done = 1'b1;
    arith_result = 64'h4000_0000_0000_0000;
    tick();
    arith_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL late_done cyc=%0d got wb_valid=%b in_ready=%b expected 0 1",
                 i, wb_valid, in_ready);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fast();
    test_arith();
    test_timeout();
    test_illegal();
    test_back_to_back();
    test_reset_mid_arith();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_issue_seq.md
Name: fpu_issue_seq

Overview:
- Sits directly downstream of the FP instruction decoder and consumes its 6-bit fpu_op code and fpu_rd flag together with the register operands.
- Accepts one FP operation at a time over a valid/ready handshake.
- Single-cycle ops go to the combinational fast unit. Multi-cycle arithmetic (add/sub/mul/div/sqrt) goes to the arithmetic unit over a start/done handshake.
- Formats the result (NaN-boxing or zero-extension) and presents it to writeback, holding it until accepted.

Parameters:
- BUS_WIDTH, 64, operand/result width
- FPU_OP_LEN, 6, width of the op code
- TIMEOUT_CYCLES, 64, maximum cycles to wait for arith_done

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  op presented
- in_ready  out  1  block can accept
- in_op  in  FPU_OP_LEN  decoded op code
- in_fpu_rd  in  1  1 = destination is FP register
- in_rd_addr  in  5  destination index
- in_rs1_data  in  BUS_WIDTH  operand 1
- in_rs2_data  in  BUS_WIDTH  operand 2
- fast_op  out  FPU_OP_LEN  = in_op (combinational)
- fast_a  out  BUS_WIDTH  = in_rs1_data (combinational)
- fast_b  out  BUS_WIDTH  = in_rs2_data (combinational)
- fast_result  in  BUS_WIDTH  combinational result of the fast unit
- arith_start  out  1  one-cycle start pulse
- arith_op  out  FPU_OP_LEN  registered op
- arith_a  out  BUS_WIDTH  registered operand 1
- arith_b  out  BUS_WIDTH  registered operand 2
- arith_done  in  1  arith result valid (pulse)
- arith_result  in  BUS_WIDTH  arith result
- wb_valid  out  1  result presented
- wb_ready  in  1  writeback accepts
- wb_fp  out  1  1 = FP regfile, 0 = integer regfile
- wb_rd_addr  out  5  destination
- wb_data  out  BUS_WIDTH  formatted result
- wb_illegal  out  1  op code unassigned; qualified by wb_valid
- timeout_err  out  1  sticky; set on arith timeout

Behaviour:
- Reset: clk single clock; rst asynchronous, active-high. The FSM goes to IDLE. All outputs are 0 except in_ready=1. Op and operand registers and the counter clear to 0. An in-flight op is dropped.
- Op classes:
  - ARITH: 000000–001001.
  - FAST: 010000–011111, 100000, 100001.
  - ILLEGAL: everything else.
- in_ready = (state==IDLE). Accept = in_valid & in_ready.
- IDLE:
  - On accept, capture op, operands, rd_addr and fpu_rd.
  - ARITH -> ARITH state.
  - FAST -> capture formatted fast_result -> WB.
  - ILLEGAL -> WB with data 0 and wb_illegal=1.
- ARITH state:
  - arith_start=1 only in the first ARITH cycle.
  - The counter increments each cycle.
  - arith_done=1 -> capture the formatted arith_result -> WB.
  - If the counter reaches TIMEOUT_CYCLES-1 with no done: -> WB with canonical NaN, and set timeout_err.
  - If done and timeout occur in the same cycle, done wins.
- WB state:
  - wb_valid=1; data, rd, fp and illegal are held stable.
  - wb_ready=1 -> IDLE; no new op is accepted in that same cycle.
- Latency:
  - FAST: accept at cycle N -> wb_valid at N+1.
  - ARITH: start at N+1; done at M -> wb_valid at M+1.
- wb_fp = captured fpu_rd.
- Formatting:
  - fpu_rd=1, op<100000 and op[0]=1 (single precision): wb_data = {32'hFFFF_FFFF, result[31:0]}.
  - fpu_rd=0 and op in compare range 010100–011001: wb_data = {63'b0, result[0]}.
  - All other cases (including fmv.x.d and fmv.d.x): full 64-bit pass-through.
- Canonical NaN:
  - Double: 64'h7FF8_0000_0000_0000.
  - Single: 64'hFFFF_FFFF_7FC0_0000.
- arith_done outside the ARITH state is ignored.
- timeout_err clears only on rst.
- in_valid while busy is not accepted. The upstream stage must hold its inputs.

Decomposition:
- Shared package fpu_pkg:
  - op code localparams (FPU_FADD_D … FPU_FMV_D_X).
  - op-class function or enum (ARITH/FAST/ILLEGAL).
  - canonical NaN constants.
  - FSM state encoding.
- One combinational sub-module, fpu_result_fmt (op, fpu_rd, raw result -> formatted wb_data). It is instanced once, muxing fast_result or arith_result.

Test Plan:
- fsgnj.s (011011), rd FP, fast_result=64'h0000_0000_3F80_0000 -> next cycle wb_valid=1, wb_fp=1, wb_data=64'hFFFF_FFFF_3F80_0000.
- flt.d (010110), fpu_rd=0, fast_result=64'hDEAD_BEEF_0000_0001 -> wb_data=64'h1, wb_fp=0.
- fdiv.d (000110):
  - arith_start pulses exactly 1 cycle after accept; in_ready stays 0.
  - arith_done after 20 cycles with 64'h4000_0000_0000_0000 -> wb_data passes through.
  - With wb_ready held 0 for 3 cycles, the outputs stay stable; in_ready rises the cycle after wb_ready.
- fsqrt.s (001001), arith_done never asserted -> after 64 cycles wb_data=64'hFFFF_FFFF_7FC0_0000 and timeout_err=1, which stays set after the next op.
- Op 6'b111000 -> wb_illegal=1, wb_data=0, no arith_start.
- rst asserted mid-ARITH (cycle 5) -> immediately in_ready=1, wb_valid=0; a late arith_done is ignored and no wb_valid follows.
